// File: rtl/fetch_pc_unit.sv
// Fetch-stage next-PC generator: direct-mapped BTB lookup, IF/ID/EX prediction
// metadata, mispredict detection/redirect at EX and the BHT update strobe.
module fetch_pc_unit #(
  parameter int unsigned     PC_W      = 8,
  parameter int unsigned     BTB_IDX_W = 4,
  parameter logic [PC_W-1:0] RESET_PC  = 8'h00,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  output logic [PC_W-1:0]  bpu_pc,
  input  logic             bpu_prediction,
  output logic [PC_W-1:0]  fetch_pc,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  output logic             bpu_update,
  output logic             bpu_taken,
  output logic [PC_W-1:0]  bpu_update_pc,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned BTB_N = 2 ** BTB_IDX_W;
  localparam int unsigned TAG_W = PC_W - BTB_IDX_W;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
  } meta_t;

  logic [PC_W-1:0]              pc_q, pc_d;
  meta_t                        id_q, id_d;
  meta_t                        ex_q, ex_d;
  logic [BTB_N-1:0]             btb_v_q, btb_v_d;
  logic [BTB_N-1:0][TAG_W-1:0]  btb_tag_q, btb_tag_d;
  logic [BTB_N-1:0][PC_W-1:0]   btb_tgt_q, btb_tgt_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic [BTB_IDX_W-1:0] idx_if;
  logic [BTB_IDX_W-1:0] idx_ex;
  logic                 btb_hit;
  logic                 pred_taken_if;
  logic [PC_W-1:0]      pc_inc;
  logic [PC_W-1:0]      pred_target_if;
  logic                 ex_resolve;
  logic                 mispredict;
  logic [PC_W-1:0]      redirect_pc;

  // BTB lookup on the current fetch address and EX resolution.
  always_comb begin
    idx_if         = pc_q[BTB_IDX_W-1:0];
    idx_ex         = ex_q.pc[BTB_IDX_W-1:0];
    btb_hit        = btb_v_q[idx_if] && (btb_tag_q[idx_if] == pc_q[PC_W-1:BTB_IDX_W]);
    pred_taken_if  = btb_hit && bpu_prediction;
    pc_inc         = pc_q + PC_W'(1);
    pred_target_if = pred_taken_if ? btb_tgt_q[idx_if] : pc_inc;
    ex_resolve     = ex_q.valid && ex_branch;
    mispredict     = ex_resolve &&
                     ((ex_taken != ex_q.pred_taken) ||
                      (ex_taken && (ex_target != ex_q.pred_target)));
    redirect_pc    = ex_taken ? ex_target : (ex_q.pc + PC_W'(1));
  end

  // Next-state: redirect beats stall, stall beats prediction.
  always_comb begin
    pc_d      = pc_inc;
    id_d      = id_q;
    ex_d      = id_q;
    btb_v_d   = btb_v_q;
    btb_tag_d = btb_tag_q;
    btb_tgt_d = btb_tgt_q;
    cnt_d     = cnt_q;

    if (mispredict) begin
      pc_d          = redirect_pc;
      id_d.valid    = 1'b0;
      ex_d.valid    = 1'b0;
    end else if (stall) begin
      pc_d          = pc_q;
      ex_d.valid    = 1'b0;
    end else begin
      pc_d             = pred_target_if;
      id_d.valid       = 1'b1;
      id_d.pc          = pc_q;
      id_d.pred_taken  = pred_taken_if;
      id_d.pred_target = pred_target_if;
    end

    // Only taken resolutions allocate; lookup above still sees the old entry.
    if (ex_resolve && ex_taken) begin
      btb_v_d[idx_ex]   = 1'b1;
      btb_tag_d[idx_ex] = ex_q.pc[PC_W-1:BTB_IDX_W];
      btb_tgt_d[idx_ex] = ex_target;
    end

    if (mispredict && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      id_q      <= '0;
      ex_q      <= '0;
      btb_v_q   <= '0;
      btb_tag_q <= '0;
      btb_tgt_q <= '0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      id_q      <= id_d;
      ex_q      <= ex_d;
      btb_v_q   <= btb_v_d;
      btb_tag_q <= btb_tag_d;
      btb_tgt_q <= btb_tgt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fetch_pc         = pc_q;
  assign bpu_pc           = pc_q;
  assign flush            = mispredict;
  assign bpu_update       = ex_resolve;
  assign bpu_taken        = ex_taken;
  assign bpu_update_pc    = ex_q.pc;
  assign mispredict_count = cnt_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage next-PC generator directly upstream of the 2-bit BHT predictor.
- Drives the PC that indexes the BHT and consumes the BHT's combinational taken/not-taken prediction.
- Contains a direct-mapped branch target buffer (BTB) and carries prediction metadata alongside the IF->ID->EX pipeline.
- At EX it detects mispredicts, redirects fetch, and produces the BHT update strobe.

Parameters:
PC_W, 8, PC/address width (word-addressed, increment by 1)
BTB_IDX_W, 4, BTB index bits; BTB has 2**BTB_IDX_W entries, tag = pc[PC_W-1:BTB_IDX_W]
RESET_PC, 8'h00, PC value loaded by reset
CNT_W, 16, width of mispredict counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hazard stall: hold PC and IF/ID metadata, insert bubble into EX metadata
bpu_pc  out  PC_W  PC presented to BHT index (equals fetch_pc)
bpu_prediction  in  1  BHT prediction for bpu_pc, combinational, same cycle
fetch_pc  out  PC_W  current fetch address to instruction memory
ex_branch  in  1  instruction in EX is a conditional branch (qualified internally by EX metadata valid)
ex_taken  in  1  resolved branch direction in EX
ex_target  in  PC_W  resolved branch target in EX
bpu_update  out  1  BHT update strobe
bpu_taken  out  1  BHT update direction
bpu_update_pc  out  PC_W  BHT update index (PC of resolved branch)
flush  out  1  kill IF/ID and ID/EX instructions this cycle
mispredict_count  out  CNT_W  saturating count of mispredicts

Behaviour:
- Reset (async, low): pc=RESET_PC; all BTB valid bits=0; ID and EX metadata valid=0; mispredict_count=0. Consequently flush=0 and bpu_update=0 while reset is held.
- BTB lookup: combinational on fetch_pc. btb_hit = valid[idx] && tag match. pred_taken_if = btb_hit && bpu_prediction. pred_target_if = BTB target when pred_taken_if, else pc+1.
- Metadata pipeline:
  - Each stage holds {valid, pc, pred_taken, pred_target}.
  - IF->ID on every non-stalled, non-flushed edge; ID valid=1.
  - ID->EX every edge.
  - stall=1 (no mispredict): ID holds its contents; EX loads valid=0 (bubble).
- Mispredict, evaluated when ex_v && ex_branch:
  - ex_taken != ex_pred_taken, or
  - ex_taken && ex_target != ex_pred_target.
- Redirect address: ex_taken ? ex_target : ex_pc+1.
- Next-PC priority, highest first:
  1. mispredict -> redirect address.
  2. stall -> hold pc.
  3. pred_taken_if -> BTB target.
  4. otherwise pc+1, wrapping 8'hFF->8'h00.
- flush = mispredict (combinational, same cycle). On the following edge ID valid=0 and EX valid=0. Mispredict overrides stall.
- BTB write: on the edge where ex_v && ex_branch && ex_taken, entry[ex_pc idx] <= {valid=1, tag, ex_target}. Not-taken resolution leaves the BTB unchanged.
- BTB write/read of the same index in the same cycle: the read returns the old contents; the new entry is visible next cycle.
- BHT update outputs:
  - bpu_update = ex_v && ex_branch.
  - bpu_taken = ex_taken.
  - bpu_update_pc = ex_pc.
  - All combinational, so the BHT samples them on the same edge as the BTB write.
- mispredict_count increments by 1 per mispredict cycle and saturates at all-ones.
- Latency: fetch to resolution = 2 cycles with no stalls; mispredict penalty = 2 fetch slots.
- Reset asserted mid-operation clears everything immediately; in-flight metadata is discarded and no update is emitted.

Test Plan:
- Release reset, no branches, no stall -> fetch_pc sequence 00,01,02,...,FF,00 (wrap). bpu_update=0, flush=0 throughout.
- Branch at pc 04, ex_branch=1, ex_taken=1, ex_target=20 when pc 04 reaches EX (cold BTB) -> flush=1 that cycle, next fetch_pc=20, mispredict_count=1, bpu_update=1 with bpu_update_pc=04 and bpu_taken=1. Next fetch of 04 with bpu_prediction=1 -> fetch_pc after 04 is 20 (BTB hit).
- Same branch, BTB hit, bpu_prediction=1, resolved ex_taken=0 -> flush=1, next fetch_pc=05, count increments; BTB entry unchanged.
- stall=1 for 3 cycles at pc 10 -> fetch_pc stays 10 for 3 cycles; EX sees 3 bubbles (bpu_update=0 even if ex_branch=1). Mispredict during stall -> redirect taken, flush=1.
- Tag alias: BTB entry for 04->20 present, fetch pc 14 (same idx, different tag) with bpu_prediction=1 -> no hit, fetch_pc after 14 is 15.
- Reset pulse while a mispredicting branch sits in EX -> fetch_pc=00, no flush, count=0, BTB invalid; force count to FFFF then mispredict -> count stays FFFF.
